wakeup_sync_tx: RTL and testbench

Parametrised wake-up/sync transmit sequencer. Validates a wake-up edge, then starts a packet either on the first stage-2 comparator edge (mode 1) or after a programmable fixed delay (mode 0). Generates a bit-rate strobe from `clki` and emits a scrambled bit stream: zero preamble, payload from an internal pattern or an external source, zero tail. Sits between the wake-up receiver front end and the transmit modulator.

---
 rtl/wakeup_sync_pkg.sv | 15 +
 rtl/sync_edge_det.sv | 22 ++
 rtl/wakeup_sync_tx.sv | 206 ++++++++++++++++++++
 tb/tb_wakeup_sync_tx.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wakeup_sync_pkg.sv
// Shared types and constants for the wake-up/sync
// transmit sequencer.
package wakeup_sync_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    TX
  } state_t;

  localparam logic [7:0] SCR_TAPS_DEF = 8'hD9;
  localparam int unsigned PAT_PERIOD = 8;
  localparam int unsigned PAT_ONES = 4;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser plus history flop;
// flags a rising edge of the async input.
module sync_edge_det (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic rise_o
);

  logic [2:0] sh_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sh_q <= '0;
    end else begin
      sh_q <= {sh_q[1:0], async_i};
    end
  end

  assign rise_o = (sh_q[2:1] == 2'b01);

endmodule

// File: rtl/wakeup_sync_tx.sv
// Wake-up validation, packet start and scrambled
// bit-stream generation for the transmit modulator.
module wakeup_sync_tx
  import wakeup_sync_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 100,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned PREAMBLE_LEN = 432,
  parameter int unsigned TAIL_LEN     = 32,
  parameter logic [7:0]  SCR_TAPS     = SCR_TAPS_DEF
) (
  input  logic             clki,
  input  logic             rst_n,
  input  logic             wake_up,
  input  logic             comp_out,
  input  logic             use_stage2,
  input  logic             pat_sel,
  input  logic [CNT_W-1:0] pkt_duration,
  input  logic [CNT_W-1:0] fixed_delay,
  input  logic [CNT_W-1:0] timeout,
  input  logic             data_bit,
  output logic             wu_valid,
  output logic             busy,
  output logic             bit_strobe,
  output logic [CNT_W-1:0] bit_idx,
  output logic             tx_bit,
  output logic             data_req,
  output logic             done,
  output logic             timeout_err
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned XW = CNT_W + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
  localparam logic [XW-1:0] PRE_X = XW'(PREAMBLE_LEN);
  localparam logic [XW-1:0] TAIL_X = XW'(TAIL_LEN);
  localparam logic [CNT_W-1:0] PRE_C = CNT_W'(PREAMBLE_LEN);
  localparam logic [CNT_W-1:0] PER_C = CNT_W'(PAT_PERIOD);
  localparam logic [CNT_W-1:0] ONES_C = CNT_W'(PAT_ONES);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  state_t state_q, state_d;
  logic [CNT_W-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] dur_q, dur_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0] s_q, s_d;
  logic pat_q, pat_d;
  logic txb_q, txb_d;
  logic done_q, done_d;
  logic terr_q, terr_d;

  logic wu_rise;
  logic cmp_rise;

  sync_edge_det u_wu_sync (
    .clk_i   (clki),
    .rst_ni  (rst_n),
    .async_i (wake_up),
    .rise_o  (wu_rise)
  );

  sync_edge_det u_cmp_sync (
    .clk_i   (clki),
    .rst_ni  (rst_n),
    .async_i (comp_out),
    .rise_o  (cmp_rise)
  );

  logic [XW-1:0] idx_x;
  logic [CNT_W-1:0] pay_off;
  logic [CNT_W-1:0] tmr_inc;
  logic in_pre;
  logic in_pay;
  logic int_d;
  logic fb;
  logic pay_bit;
  logic new_bit;
  logic strobe;
  logic last_cyc;
  logic pkt_end;
  logic tmo_hit;
  logic start;

  // Widened compare keeps short packets from
  // underflowing the payload end bound.
  assign idx_x    = {1'b0, idx_q};
  assign in_pre   = idx_x < PRE_X;
  assign in_pay   = !in_pre &&
                    (idx_x + TAIL_X < {1'b0, dur_q});
  assign pay_off  = idx_q - PRE_C;
  assign int_d    = (pay_off % PER_C) < ONES_C;
  assign fb       = ^(s_q & SCR_TAPS);
  assign pay_bit  = (pat_q ? data_bit : int_d) ^ fb;
  assign new_bit  = in_pay & pay_bit;
  assign strobe   = (state_q == TX) &&
                    (div_q == '0) &&
                    (idx_q < dur_q);
  assign last_cyc = div_q == DIV_LAST;
  assign pkt_end  = (dur_q == '0) ||
                    (last_cyc && (idx_q == dur_q - ONE_C));
  assign tmr_inc  = (tmr_q == '1) ? tmr_q : tmr_q + ONE_C;
  assign tmo_hit  = (timeout != '1) && (tmr_q == timeout);
  assign start    = use_stage2 ? cmp_rise
                               : (tmr_q == fixed_delay);

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    idx_d   = idx_q;
    dur_d   = dur_q;
    div_d   = div_q;
    s_d     = s_q;
    pat_d   = pat_q;
    txb_d   = txb_q;
    done_d  = 1'b0;
    terr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wu_rise) begin
          state_d = ARMED;
          tmr_d   = '0;
        end
      end
      ARMED: begin
        tmr_d = tmr_inc;
        if (start) begin
          state_d = TX;
          dur_d   = pkt_duration;
          pat_d   = pat_sel;
          s_d     = '0;
          idx_d   = '0;
          div_d   = '0;
        end else if (tmo_hit) begin
          state_d = IDLE;
          terr_d  = 1'b1;
        end else if (wu_rise) begin
          tmr_d = '0;
        end
      end
      TX: begin
        if (strobe) begin
          txb_d = new_bit;
          if (in_pre) begin
            s_d = '0;
          end else if (in_pay) begin
            s_d = {s_q[6:0], pay_bit};
          end
        end
        if (pkt_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
          txb_d   = 1'b0;
          idx_d   = '0;
          div_d   = '0;
        end else if (last_cyc) begin
          div_d = '0;
          idx_d = idx_q + ONE_C;
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clki) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      idx_q   <= '0;
      dur_q   <= '0;
      div_q   <= '0;
      s_q     <= '0;
      pat_q   <= 1'b0;
      txb_q   <= 1'b0;
      done_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      idx_q   <= idx_d;
      dur_q   <= dur_d;
      div_q   <= div_d;
      s_q     <= s_d;
      pat_q   <= pat_d;
      txb_q   <= txb_d;
      done_q  <= done_d;
      terr_q  <= terr_d;
    end
  end

  // The new bit is visible in its own strobe cycle.
  assign tx_bit      = strobe ? new_bit : txb_q;
  assign wu_valid    = (state_q == ARMED);
  assign busy        = (state_q == TX);
  assign bit_strobe  = strobe;
  assign bit_idx     = idx_q;
  assign data_req    = strobe && in_pay && pat_q;
  assign done        = done_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_wakeup_sync_tx.sv
// Directed bench for wakeup_sync_tx: start modes,
// timeout, scrambled payload and mid-packet reset.
module tb_wakeup_sync_tx;

  localparam int D = 20;
  localparam int PRE = 432;
  localparam int TAIL = 32;

  logic clki = 1'b0;
  logic rst_n;
  logic wake_up;
  logic comp_out;
  logic use_stage2;
  logic pat_sel;
  logic data_bit;
  logic [31:0] pkt_duration;
  logic [31:0] fixed_delay;
  logic [31:0] timeout;
  logic wu_valid;
  logic busy;
  logic bit_strobe;
  logic [31:0] bit_idx;
  logic tx_bit;
  logic data_req;
  logic done;
  logic timeout_err;
  logic [511:0] ext_pat;

  always #5 clki = ~clki;

  assign data_bit = ext_pat[bit_idx[8:0]];

  wakeup_sync_tx #(
    .CLK_DIV (D)
  ) dut (
    .clki         (clki),
    .rst_n        (rst_n),
    .wake_up      (wake_up),
    .comp_out     (comp_out),
    .use_stage2   (use_stage2),
    .pat_sel      (pat_sel),
    .pkt_duration (pkt_duration),
    .fixed_delay  (fixed_delay),
    .timeout      (timeout),
    .data_bit     (data_bit),
    .wu_valid     (wu_valid),
    .busy         (busy),
    .bit_strobe   (bit_strobe),
    .bit_idx      (bit_idx),
    .tx_bit       (tx_bit),
    .data_req     (data_req),
    .done         (done),
    .timeout_err  (timeout_err)
  );

  int cyc = 0;
  always @(posedge clki) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d",
                  tag, got, exp);
  endtask

  // Passive monitor: per-bit capture and counters.
  logic bits [512];
  int nstb = 0;
  int ndone = 0;
  int nterr = 0;
  int nreq = 0;
  int req_bad = 0;
  int nbusy = 0;
  int idx_bad = 0;
  int hold_bad = 0;
  int done_bad = 0;
  int nxt = 0;
  logic prev_tx = 1'b0;

  always @(negedge clki) begin
    if (bit_strobe === 1'b1) begin
      if (bit_idx != nxt) idx_bad++;
      nxt = bit_idx + 1;
      bits[bit_idx[8:0]] = tx_bit;
      nstb++;
    end else if (busy === 1'b1 && tx_bit !== prev_tx) begin
      hold_bad++;
    end
    if (busy !== 1'b1) nxt = 0;
    if (data_req === 1'b1) begin
      nreq++;
      if (bit_strobe !== 1'b1 || bit_idx < PRE ||
          bit_idx + TAIL >= pkt_duration) req_bad++;
    end
    if (done === 1'b1) begin
      ndone++;
      if (busy !== 1'b0 || tx_bit !== 1'b0) done_bad++;
    end
    if (timeout_err === 1'b1) nterr++;
    if (busy === 1'b1) nbusy++;
    prev_tx = tx_bit;
  end

  function automatic logic sig(input int s);
    case (s)
      0: return busy;
      1: return done;
      2: return bit_strobe;
      3: return timeout_err;
      default: return wu_valid;
    endcase
  endfunction

  task automatic wait_sig(input int s, input int lim,
                          input string tag, output int n);
    n = 0;
    do begin
      @(negedge clki);
      n++;
    end while (sig(s) !== 1'b1 && n < lim);
    if (sig(s) !== 1'b1) chk({tag, "_tmo"}, 0, 1);
  endtask

  int t_wu = 0;

  task automatic wake();
    int n;
    wake_up = 1'b1;
    wait_sig(4, 8, "wake", n);
    chk("wu_lat", n, 3);
    t_wu = cyc;
    wake_up = 1'b0;
  endtask

  function automatic logic [63:0] outs();
    return {wu_valid, busy, bit_strobe, bit_idx,
            tx_bit, data_req, done, timeout_err};
  endfunction

  function automatic int nz(input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++)
      if (bits[i] !== 1'b0) c++;
    return c;
  endfunction

  function automatic logic [7:0] pay8();
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[7-i] = bits[PRE+i];
    return b;
  endfunction

  // Reference scrambler over the captured bits.
  function automatic int ref_bad(input int dur, input bit ext);
    logic [7:0] s = '0;
    logic t;
    logic d;
    int bad = 0;
    for (int n = 0; n < dur; n++) begin
      if (n < PRE) begin
        t = 1'b0;
        s = '0;
      end else if (n < dur - TAIL) begin
        d = ext ? ext_pat[n] : (((n - PRE) % 8) < 4);
        t = d ^ (^(s & 8'hD9));
        s = {s[6:0], t};
      end else begin
        t = 1'b0;
      end
      if (bits[n] !== t) bad++;
    end
    return bad;
  endfunction

  initial begin
    int n;
    int t0;
    int s_stb;
    int s_done;
    int s_terr;
    int s_req;
    int s_busy;
    rst_n = 1'b0;
    wake_up = 1'b0;
    comp_out = 1'b0;
    use_stage2 = 1'b1;
    pat_sel = 1'b0;
    pkt_duration = 472;
    fixed_delay = 0;
    timeout = 60000;
    ext_pat = '0;
    repeat (3) @(negedge clki);
    chk("rst_outs", outs(), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clki);
    chk("idle_outs", outs(), 0);

    // Mode 1, internal pattern
    s_stb = nstb;
    s_done = ndone;
    wake();
    repeat (500) @(negedge clki);
    comp_out = 1'b1;
    wait_sig(0, 8, "t1_busy", n);
    chk("t1_busy_lat", n, 3);
    chk("t1_first_stb", {bit_strobe, bit_idx}, {1'b1, 32'd0});
    comp_out = 1'b0;
    t0 = cyc;
    wait_sig(1, 472 * D + 50, "t1_done", n);
    chk("t1_done_dt", cyc - t0, 472 * D);
    @(negedge clki);
    chk("t1_done_pulse", done, 0);
    #1;
    chk("t1_nstb", nstb - s_stb, 472);
    chk("t1_ndone", ndone - s_done, 1);
    chk("t1_pre_zero", nz(0, PRE - 1), 0);
    chk("t1_pay", pay8(), 8'hAB);
    chk("t1_tail_zero", nz(440, 471), 0);
    chk("t1_ref", ref_bad(472, 1'b0), 0);

    // Mode 1 timeout
    timeout = 1000;
    s_stb = nstb;
    s_terr = nterr;
    wake();
    wait_sig(3, 1100, "t2_terr", n);
    chk("t2_terr_dt", cyc - t_wu, 1001);
    chk("t2_wu_fall", {wu_valid, busy}, 0);
    @(negedge clki);
    chk("t2_terr_pulse", timeout_err, 0);
    #1;
    chk("t2_nterr", nterr - s_terr, 1);
    chk("t2_no_stb", nstb - s_stb, 0);

    // Mode 0 fixed delay, comparator ignored
    use_stage2 = 1'b0;
    fixed_delay = 25342;
    timeout = 60000;
    pkt_duration = 3;
    s_stb = nstb;
    s_terr = nterr;
    wake();
    repeat (100) @(negedge clki);
    comp_out = 1'b1;
    repeat (5) @(negedge clki);
    comp_out = 1'b0;
    wait_sig(2, 26000, "t3_stb", n);
    chk("t3_start_dt", cyc - t_wu, 25343);
    wait_sig(1, 4 * D, "t3_done", n);
    #1;
    chk("t3_nstb", nstb - s_stb, 3);
    chk("t3_nterr", nterr - s_terr, 0);

    // Start beats timeout in the same cycle
    use_stage2 = 1'b1;
    timeout = 40;
    pkt_duration = 2;
    s_terr = nterr;
    wake();
    repeat (38) @(negedge clki);
    comp_out = 1'b1;
    wait_sig(0, 8, "t4_busy", n);
    chk("t4_busy_lat", n, 3);
    comp_out = 1'b0;
    wait_sig(1, 3 * D, "t4_done", n);
    #1;
    chk("t4_no_terr", nterr - s_terr, 0);

    // Comparator pulses while idle are dropped
    timeout = 50;
    s_stb = nstb;
    comp_out = 1'b1;
    repeat (5) @(negedge clki);
    comp_out = 1'b0;
    repeat (10) @(negedge clki);
    chk("t5_idle", {wu_valid, busy}, 0);
    wake();
    wait_sig(3, 60, "t5_terr", n);
    chk("t5_terr_dt", cyc - t_wu, 51);
    #1;
    chk("t5_nstb", nstb - s_stb, 0);

    // Zero-length packet
    use_stage2 = 1'b0;
    fixed_delay = 3;
    pkt_duration = 0;
    s_stb = nstb;
    s_done = ndone;
    s_busy = nbusy;
    wake();
    wait_sig(1, 20, "t6_done", n);
    #1;
    chk("t6_busy_cyc", nbusy - s_busy, 1);
    chk("t6_nstb", nstb - s_stb, 0);
    chk("t6_ndone", ndone - s_done, 1);

    // External payload, pat_sel latched at start
    for (int i = 0; i < 16; i++)
      ext_pat[i*32 +: 32] = $urandom;
    pat_sel = 1'b1;
    fixed_delay = 5;
    pkt_duration = 480;
    s_req = nreq;
    wake();
    wait_sig(0, 10, "t7_busy", n);
    pat_sel = 1'b0;
    wait_sig(1, 480 * D + 50, "t7_done", n);
    #1;
    chk("t7_nreq", nreq - s_req, 16);
    chk("t7_req_bad", req_bad, 0);
    chk("t7_ref", ref_bad(480, 1'b1), 0);

    // Reset at bit 200, then a fresh packet
    pkt_duration = 300;
    wake();
    n = 0;
    do begin
      @(negedge clki);
      n++;
    end while (!(bit_strobe === 1'b1 && bit_idx == 200) &&
               n < 210 * D);
    chk("t8_at200", {busy, bit_strobe, bit_idx},
        {2'b11, 32'd200});
    rst_n = 1'b0;
    @(negedge clki);
    chk("t8_rst_outs", outs(), 0);
    rst_n = 1'b1;
    pkt_duration = 10;
    repeat (3) @(negedge clki);
    #1;
    s_stb = nstb;
    s_done = ndone;
    @(negedge clki);
    wake();
    wait_sig(1, 11 * D + 20, "t8_done", n);
    #1;
    chk("t8_nstb", nstb - s_stb, 10);
    chk("t8_ndone", ndone - s_done, 1);

    chk("idx_seq", idx_bad, 0);
    chk("tx_hold", hold_bad, 0);
    chk("done_busy", done_bad, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
